// File: rtl/retire_stage_pkg.sv
// Shared types and constants for the retire stage and its architectural map table.
package retire_stage_pkg;
    localparam int N_ARCH_REGS      = 32;
    localparam int AR_BITS          = $clog2(N_ARCH_REGS);
    localparam int PR_BITS          = 6;
    localparam int XLEN             = 32;
    localparam int SUPERSCALAR_WAYS = 2;

    // One ROB commit slot; the slot is live only when complete is set.
    typedef struct packed {
        logic               complete;
        logic [AR_BITS-1:0] ar_idx;
        logic [PR_BITS-1:0] t_idx;
        logic [PR_BITS-1:0] told_idx;
        logic               precise_state_enable;
        logic               halt;
        logic [XLEN-1:0]    target_pc;
    } ROB_PACKET;

    typedef struct packed {
        logic               valid;
        logic [PR_BITS-1:0] told_idx;
    } RETIRE_FREE_PACKET;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RECOVER = 2'd1,
        HALTED  = 2'd2
    } RETIRE_STATE;
endpackage

// File: rtl/retire_stage_amt.sv
// Architectural map table: identity on reset, ordered write ports (higher way wins).
module arch_map_table
    import retire_stage_pkg::*;
#(
    parameter int N_WAYS = SUPERSCALAR_WAYS
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [N_WAYS-1:0]                     wr_en,
    input  logic [N_WAYS-1:0][AR_BITS-1:0]        wr_idx,
    input  logic [N_WAYS-1:0][PR_BITS-1:0]        wr_data,
    output logic [N_ARCH_REGS-1:0][PR_BITS-1:0]   map
);
    // Later ways are applied last so the youngest writer to a register wins.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int r = 0; r < N_ARCH_REGS; r++)
                map[r] <= PR_BITS'(r);
        end else begin
            for (int w = 0; w < N_WAYS; w++)
                if (wr_en[w])
                    map[wr_idx[w]] <= wr_data[w];
        end
    end
endmodule

// File: rtl/retire_stage.sv
// Retire stage: in-order commit mask, AMT update, free-list return, squash/halt FSM.
module retire_stage
    import retire_stage_pkg::*;
#(
    parameter int N_WAYS = SUPERSCALAR_WAYS,
    parameter int CNT_W  = 32
) (
    input  logic                                clock,
    input  logic                                reset,
    input  ROB_PACKET         [N_WAYS-1:0]      rob_retire_in,
    output RETIRE_FREE_PACKET [N_WAYS-1:0]      free_out,
    output logic [N_ARCH_REGS-1:0][PR_BITS-1:0] arch_map_out,
    output logic                                squash,
    output logic [XLEN-1:0]                     redirect_pc,
    output logic                                halted,
    output logic [CNT_W-1:0]                    retired_count
);
    localparam int NA_W = $clog2(N_WAYS + 1);

    RETIRE_STATE                      state;
    logic [N_WAYS-1:0]                accept;
    logic [N_WAYS-1:0]                amt_we;
    logic [N_WAYS-1:0][AR_BITS-1:0]   amt_idx;
    logic [N_WAYS-1:0][PR_BITS-1:0]   amt_data;
    logic [NA_W-1:0]                  n_acc;
    logic                             halt_hit;
    logic                             pse_hit;
    logic [XLEN-1:0]                  pse_pc;
    logic                             open;

    // Accept ways oldest-first; a gap or a halt/precise-state entry closes the bundle.
    always_comb begin
        open     = (state == RUN);
        accept   = '0;
        n_acc    = '0;
        halt_hit = 1'b0;
        pse_hit  = 1'b0;
        pse_pc   = '0;
        for (int i = 0; i < N_WAYS; i++) begin
            if (open && rob_retire_in[i].complete) begin
                accept[i] = 1'b1;
                n_acc     = n_acc + NA_W'(1);
                if (rob_retire_in[i].halt) begin
                    halt_hit = 1'b1;
                    open     = 1'b0;
                end else if (rob_retire_in[i].precise_state_enable) begin
                    pse_hit  = 1'b1;
                    pse_pc   = rob_retire_in[i].target_pc;
                    open     = 1'b0;
                end
            end else begin
                open = 1'b0;
            end
        end
    end

    // x0 is never remapped, so its commits only bump the counter.
    always_comb begin
        for (int i = 0; i < N_WAYS; i++) begin
            amt_we[i]   = accept[i] && (rob_retire_in[i].ar_idx != '0);
            amt_idx[i]  = rob_retire_in[i].ar_idx;
            amt_data[i] = rob_retire_in[i].t_idx;
        end
    end

    arch_map_table #(.N_WAYS(N_WAYS)) u_amt (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (amt_we),
        .wr_idx  (amt_idx),
        .wr_data (amt_data),
        .map     (arch_map_out)
    );

    // State machine plus registered free list, counter and squash/halt outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= RUN;
            free_out      <= '0;
            squash        <= 1'b0;
            redirect_pc   <= '0;
            halted        <= 1'b0;
            retired_count <= '0;
        end else begin
            for (int i = 0; i < N_WAYS; i++) begin
                free_out[i].valid    <= amt_we[i];
                free_out[i].told_idx <= rob_retire_in[i].told_idx;
            end
            retired_count <= retired_count + CNT_W'(n_acc);
            squash        <= 1'b0;
            case (state)
                RUN: begin
                    if (halt_hit) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (pse_hit) begin
                        state       <= RECOVER;
                        squash      <= 1'b1;
                        redirect_pc <= pse_pc;
                    end
                end
                RECOVER: state <= RUN;
                HALTED:  state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end
endmodule
